ahb_response_mux: RTL and testbench
===================================

// Module: ahb_response_mux
// PURPOSE
// - Response-direction partner of the AHB-Lite address decoder: routes HRDATA/HREADYOUT/HRESP of
//   subordinates 0..2 back to the single manager.
// - Contains the default subordinate that answers the HSELd address region.
// - Registers the address-phase select so that the data-phase response comes from the subordinate
//   addressed one transfer earlier. Drives the global HREADY that is fed back to the decoder and
//   to all subordinates.
// PARAMETERS
// - DATA_WIDTH          32  width of HRDATA buses
// - NO_OF_SUBORDINATES   4  slots incl. default subordinate; fixed 4 in this revision
// PORTS
// - HCLK        in   1          bus clock, rising edge
// - HRESETn     in   1          reset, asynchronous assert, active-low
// - HSEL0..2    in   1 each     address-phase selects from decoder
// - HSELd       in   1          address-phase select of default subordinate
// - HTRANS      in   2          manager transfer type (IDLE=00 BUSY=01 NONSEQ=10 SEQ=11)
// - HRDATA0..2  in   DATA_WIDTH subordinate read data
// - HREADYOUT0..2 in 1 each     subordinate ready outputs
// - HRESP0..2   in   1 each     subordinate responses (0=OKAY 1=ERROR)
// - HRDATA      out  DATA_WIDTH muxed read data to manager
// - HREADY      out  1          muxed ready to manager, decoder and subordinates
// - HRESP       out  1          muxed response to manager
// - SEL_ERR     out  1          sticky select-fault flag (present only with AHB_MUX_SEL_CHECK_EN)
// BEHAVIOUR
// - Data-phase select sel_q[3:0] = {d,2,1,0}.
//   - Loads {HSELd,HSEL2,HSEL1,HSEL0} on HCLK rise when HREADY==1.
//   - Holds while HREADY==0.
// - Reset (HRESETn=0, async): sel_q=0; default-sub FSM=DS_IDLE; HREADY=1, HRESP=0, HRDATA=0.
// - Output mux, combinational from sel_q:
//   - Subordinate x selected: output its HRDATAx/HREADYOUTx/HRESPx.
//   - sel_q==0: HREADY=1, HRESP=0, HRDATA=0.
//   - Multi-hot sel_q (no macro): fixed priority 0>1>2>d.
// - Default subordinate (sub-module), FSM states DS_IDLE, DS_ERR1, DS_ERR2:
//   - DS_IDLE: HREADYOUTd=1, HRESPd=0. Goes to DS_ERR1 on HCLK when HREADY & HSELd & HTRANS[1].
//     IDLE/BUSY to HSELd stays in DS_IDLE (zero-wait OKAY).
//   - DS_ERR1: HREADYOUTd=0, HRESPd=1. Always goes to DS_ERR2.
//   - DS_ERR2: HREADYOUTd=1, HRESPd=1.
//     - Goes to DS_ERR1 if a new HSELd NONSEQ/SEQ is sampled in the same cycle (back-to-back error).
//     - Otherwise goes to DS_IDLE.
//   - HRDATAd = 0 always.
// - Error latency: addr phase T0, ERROR cycle 1 at T1 (HREADY=0), ERROR cycle 2 at T2 (HREADY=1).
//   The next address phase is accepted at T2.
// - Wait states: subordinate holds HREADYOUTx=0 -> HREADY=0. sel_q and FSM frozen except
//   DS_ERR1->DS_ERR2.
// - Reset mid-transfer: every state clears immediately; the first cycle after release is OKAY/ready.
// - Combinational loop: HREADY depends only on registered sel_q and subordinate outputs, never on
//   the current HSELx.
// CONFIGURATION
// - Macro AHB_MUX_SEL_CHECK_EN defined:
//   - sel_q not one-hot (multi-hot, or zero when the captured HTRANS[1]==1) routes to the default
//     subordinate's two-cycle ERROR.
//   - SEL_ERR port exists; it sets on the fault and clears only on reset.
// - Macro not defined:
//   - Fixed-priority mux, no SEL_ERR port.
//   - A zero select answers OKAY with zero wait states.
// STRUCTURE
// - Package ahb_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR, ds_state_t enum
//   {DS_IDLE,DS_ERR1,DS_ERR2}.
// - Sub-module ahb_default_sub: FSM plus HREADYOUTd/HRESPd/HRDATAd.
// - Top level holds sel_q, the mux and the optional check.
// TESTING
// - Reset release, no transfers -> HREADY=1, HRESP=0, HRDATA=0.
// - NONSEQ with HSEL1; sub1 returns HRDATA1=32'hDEADBEEF, OKAY, 2 wait states
//   -> HREADY low 2 cycles, then HRDATA=32'hDEADBEEF.
// - NONSEQ with HSELd -> T1 HREADY=0/HRESP=1, T2 HREADY=1/HRESP=1, T3 OKAY.
// - Back-to-back NONSEQ to HSELd -> ERROR pairs repeat with no OKAY gap.
// - IDLE with HSELd -> HREADY=1, HRESP=0, no wait.
// - HSEL0 and HSEL2 both high on NONSEQ:
//   - with macro -> ERROR pair and SEL_ERR=1.
//   - without macro -> sub0 response.
// - HRESETn asserted during DS_ERR1 -> HREADY=1 and HRESP=0 immediately.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and default-subordinate state type for the response mux.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  // A select vector is faulty when more than one slot is hot, or when none is hot for a real transfer.
  function automatic logic sel_fault(input logic [3:0] sel, input logic active);
    logic multi_hot;
    multi_hot = ((sel & (sel - 4'd1)) != 4'd0);
    return multi_hot || ((sel == 4'd0) && active);
  endfunction

endpackage

// File: rtl/ahb_default_sub.sv
// Default subordinate: zero-wait OKAY for IDLE/BUSY, two-cycle ERROR for NONSEQ/SEQ.
module ahb_default_sub
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  hready,
  input  logic                  err_req,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  ds_state_t state_r;
  logic      hreadyout_r;
  logic      hresp_r;

  // Error-response FSM; outputs are registered alongside the state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r     <= DS_IDLE;
      hreadyout_r <= 1'b1;
      hresp_r     <= HRESP_OKAY;
    end else begin
      case (state_r)
        DS_IDLE: begin
          if (hready && err_req) begin
            state_r     <= DS_ERR1;
            hreadyout_r <= 1'b0;
            hresp_r     <= HRESP_ERROR;
          end else begin
            state_r     <= DS_IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
          end
        end
        DS_ERR1: begin
          state_r     <= DS_ERR2;
          hreadyout_r <= 1'b1;
          hresp_r     <= HRESP_ERROR;
        end
        DS_ERR2: begin
          // The next address phase is accepted here, so a new error can follow with no OKAY gap.
          if (hready && err_req) begin
            state_r     <= DS_ERR1;
            hreadyout_r <= 1'b0;
            hresp_r     <= HRESP_ERROR;
          end else begin
            state_r     <= DS_IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
          end
        end
        default: begin
          state_r     <= DS_IDLE;
          hreadyout_r <= 1'b1;
          hresp_r     <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign hreadyout = hreadyout_r;
  assign hresp     = hresp_r;
  assign hrdata    = {DATA_WIDTH{1'b0}};

endmodule

// File: rtl/ahb_response_mux.sv
// AHB-Lite response mux: registers the address-phase select and routes the data-phase response.
// Optional select-fault checking and the SEL_ERR port are enabled by AHB_MUX_SEL_CHECK_EN.
module ahb_response_mux
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int NO_OF_SUBORDINATES = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL0,
  input  logic                  HSEL1,
  input  logic                  HSEL2,
  input  logic                  HSELd,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HRDATA0,
  input  logic [DATA_WIDTH-1:0] HRDATA1,
  input  logic [DATA_WIDTH-1:0] HRDATA2,
  input  logic                  HREADYOUT0,
  input  logic                  HREADYOUT1,
  input  logic                  HREADYOUT2,
  input  logic                  HRESP0,
  input  logic                  HRESP1,
  input  logic                  HRESP2,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADY,
`ifdef AHB_MUX_SEL_CHECK_EN
  output logic                  SEL_ERR,
`endif
  output logic                  HRESP
);

  logic [NO_OF_SUBORDINATES-1:0] sel_in_s;
  logic [NO_OF_SUBORDINATES-1:0] sel_r;
  logic                          active_s;
  logic                          err_req_s;
  logic                          hreadyout_d_s;
  logic                          hresp_d_s;
  logic [DATA_WIDTH-1:0]         hrdata_d_s;
  logic [DATA_WIDTH-1:0]         hrdata_s;
  logic                          hready_s;
  logic                          hresp_s;

  assign sel_in_s = {HSELd, HSEL2, HSEL1, HSEL0};

  // Classify the manager's transfer type.
  always_comb begin
    active_s = 1'b0;
    case (HTRANS)
      HTRANS_IDLE, HTRANS_BUSY:  active_s = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: active_s = 1'b1;
      default:                   active_s = 1'b0;
    endcase
  end

  // Data-phase select: captured on each accepted address phase, frozen during wait states.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_r <= {NO_OF_SUBORDINATES{1'b0}};
    end else if (HREADY) begin
      sel_r <= sel_in_s;
    end else begin
      sel_r <= sel_r;
    end
  end

`ifdef AHB_MUX_SEL_CHECK_EN
  logic fault_s;
  logic fault_r;
  logic sel_err_r;

  assign fault_s   = sel_fault(sel_in_s, active_s);
  assign err_req_s = (HSELd && active_s) || fault_s;

  // Data-phase fault marker and sticky fault flag, cleared only by reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fault_r   <= 1'b0;
      sel_err_r <= 1'b0;
    end else if (HREADY) begin
      fault_r   <= fault_s;
      sel_err_r <= sel_err_r | fault_s;
    end else begin
      fault_r   <= fault_r;
      sel_err_r <= sel_err_r;
    end
  end

  assign SEL_ERR = sel_err_r;
`else
  assign err_req_s = HSELd && active_s;
`endif

  ahb_default_sub #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_default_sub (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .hready    (HREADY),
    .err_req   (err_req_s),
    .hreadyout (hreadyout_d_s),
    .hresp     (hresp_d_s),
    .hrdata    (hrdata_d_s)
  );

  // Response mux: depends only on registered select, so HREADY never loops through HSELx.
  always_comb begin
    hrdata_s = {DATA_WIDTH{1'b0}};
    hready_s = 1'b1;
    hresp_s  = HRESP_OKAY;
`ifdef AHB_MUX_SEL_CHECK_EN
    if (fault_r) begin
      hrdata_s = hrdata_d_s;
      hready_s = hreadyout_d_s;
      hresp_s  = hresp_d_s;
    end else
`endif
    if (sel_r[0]) begin
      hrdata_s = HRDATA0;
      hready_s = HREADYOUT0;
      hresp_s  = HRESP0;
    end else if (sel_r[1]) begin
      hrdata_s = HRDATA1;
      hready_s = HREADYOUT1;
      hresp_s  = HRESP1;
    end else if (sel_r[2]) begin
      hrdata_s = HRDATA2;
      hready_s = HREADYOUT2;
      hresp_s  = HRESP2;
    end else if (sel_r[3]) begin
      hrdata_s = hrdata_d_s;
      hready_s = hreadyout_d_s;
      hresp_s  = hresp_d_s;
    end else begin
      hrdata_s = {DATA_WIDTH{1'b0}};
      hready_s = 1'b1;
      hresp_s  = HRESP_OKAY;
    end
  end

  assign HRDATA = hrdata_s;
  assign HREADY = hready_s;
  assign HRESP  = hresp_s;

endmodule

// File: tb/tb_ahb_response_mux.sv
// Self-checking bench for ahb_response_mux: directed vector table, reset corner case, random vs model.
module tb_ahb_response_mux;

  logic        hclk;
  logic        hresetn;
  logic        hsel0, hsel1, hsel2, hseld;
  logic [1:0]  htrans;
  logic [31:0] hrdata0, hrdata1, hrdata2;
  logic        hreadyout0, hreadyout1, hreadyout2;
  logic        hresp0, hresp1, hresp2;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
`ifdef AHB_MUX_SEL_CHECK_EN
  logic        sel_err;
`endif

  int checks = 0;
  int errors = 0;

  ahb_response_mux #(
    .DATA_WIDTH         (32),
    .NO_OF_SUBORDINATES (4)
  ) dut (
    .HCLK       (hclk),
    .HRESETn    (hresetn),
    .HSEL0      (hsel0),
    .HSEL1      (hsel1),
    .HSEL2      (hsel2),
    .HSELd      (hseld),
    .HTRANS     (htrans),
    .HRDATA0    (hrdata0),
    .HRDATA1    (hrdata1),
    .HRDATA2    (hrdata2),
    .HREADYOUT0 (hreadyout0),
    .HREADYOUT1 (hreadyout1),
    .HREADYOUT2 (hreadyout2),
    .HRESP0     (hresp0),
    .HRESP1     (hresp1),
    .HRESP2     (hresp2),
    .HRDATA     (hrdata),
    .HREADY     (hready),
`ifdef AHB_MUX_SEL_CHECK_EN
    .SEL_ERR    (sel_err),
`endif
    .HRESP      (hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct packed {
    logic [3:0]  sel;    // {d,2,1,0}
    logic [1:0]  trans;
    logic [2:0]  rdy;    // {2,1,0}
    logic [2:0]  rsp;    // {2,1,0}
    logic        e_rdy;
    logic        e_rsp;
    logic [31:0] e_data;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [3:0] sel, input logic [1:0] trans, input logic [2:0] rdy,
                              input logic [2:0] rsp, input logic e_rdy, input logic e_rsp,
                              input logic [31:0] e_data);
    vec_t v;
    v.sel = sel; v.trans = trans; v.rdy = rdy; v.rsp = rsp;
    v.e_rdy = e_rdy; v.e_rsp = e_rsp; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_rdy, input logic e_rsp, input logic [31:0] e_data);
    chk({tag, " hready"}, 32'(hready), 32'(e_rdy));
    chk({tag, " hresp"},  32'(hresp),  32'(e_rsp));
    chk({tag, " hrdata"}, hrdata,      e_data);
  endtask

  task automatic idle_inputs();
    {hseld, hsel2, hsel1, hsel0} = 4'b0000;
    htrans = 2'b00;
    {hreadyout2, hreadyout1, hreadyout0} = 3'b111;
    {hresp2, hresp1, hresp0} = 3'b000;
  endtask

  initial begin
    hresetn = 1'b0;
    idle_inputs();
    hrdata0 = 32'h0000_00A0;
    hrdata1 = 32'hDEAD_BEEF;
    hrdata2 = 32'h0000_00C2;

    // Directed sequence: one row per cycle, expected outputs are the data phase of the previous row.
    tbl[0]  = mk(4'b0000, 2'b00, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0);
    tbl[1]  = mk(4'b0010, 2'b10, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0);
    tbl[2]  = mk(4'b0000, 2'b00, 3'b101, 3'b000, 1'b0, 1'b0, 32'hDEAD_BEEF);
    tbl[3]  = mk(4'b0000, 2'b00, 3'b101, 3'b000, 1'b0, 1'b0, 32'hDEAD_BEEF);
    tbl[4]  = mk(4'b0000, 2'b00, 3'b111, 3'b000, 1'b1, 1'b0, 32'hDEAD_BEEF);
    tbl[5]  = mk(4'b1000, 2'b10, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0);
    tbl[6]  = mk(4'b0000, 2'b00, 3'b111, 3'b000, 1'b0, 1'b1, 32'h0);
    tbl[7]  = mk(4'b0000, 2'b00, 3'b111, 3'b000, 1'b1, 1'b1, 32'h0);
    tbl[8]  = mk(4'b1000, 2'b10, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0);
    tbl[9]  = mk(4'b1000, 2'b10, 3'b111, 3'b000, 1'b0, 1'b1, 32'h0);
    tbl[10] = mk(4'b1000, 2'b11, 3'b111, 3'b000, 1'b1, 1'b1, 32'h0);
    tbl[11] = mk(4'b0000, 2'b00, 3'b111, 3'b000, 1'b0, 1'b1, 32'h0);
    tbl[12] = mk(4'b1000, 2'b00, 3'b111, 3'b000, 1'b1, 1'b1, 32'h0);
    tbl[13] = mk(4'b0000, 2'b00, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0);
    tbl[14] = mk(4'b0101, 2'b10, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0);
`ifdef AHB_MUX_SEL_CHECK_EN
    tbl[15] = mk(4'b0000, 2'b00, 3'b011, 3'b100, 1'b0, 1'b1, 32'h0);
    tbl[16] = mk(4'b0000, 2'b00, 3'b111, 3'b000, 1'b1, 1'b1, 32'h0);
`else
    tbl[15] = mk(4'b0000, 2'b00, 3'b011, 3'b100, 1'b1, 1'b0, 32'h0000_00A0);
    tbl[16] = mk(4'b0000, 2'b00, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0);
`endif
    tbl[17] = mk(4'b0100, 2'b10, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0);
    tbl[18] = mk(4'b0000, 2'b00, 3'b111, 3'b100, 1'b1, 1'b1, 32'h0000_00C2);
    tbl[19] = mk(4'b0000, 2'b00, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0);

    repeat (3) @(posedge hclk);
    #1;
    chk_out("in_reset", 1'b1, 1'b0, 32'h0);
    hresetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      {hseld, hsel2, hsel1, hsel0} = tbl[i].sel;
      htrans = tbl[i].trans;
      {hreadyout2, hreadyout1, hreadyout0} = tbl[i].rdy;
      {hresp2, hresp1, hresp0} = tbl[i].rsp;
      @(negedge hclk);
      chk_out($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_rsp, tbl[i].e_data);
      @(posedge hclk);
      #1;
    end
`ifdef AHB_MUX_SEL_CHECK_EN
    chk("sel_err_sticky", 32'(sel_err), 32'd1);
`endif

    // Reset asserted while the default subordinate is in its first ERROR cycle.
    idle_inputs();
    {hseld, hsel2, hsel1, hsel0} = 4'b1000;
    htrans = 2'b10;
    @(negedge hclk);
    chk_out("rst_addr", 1'b1, 1'b0, 32'h0);
    @(posedge hclk);
    #1;
    idle_inputs();
    #1;
    chk_out("rst_err1", 1'b0, 1'b1, 32'h0);
    hresetn = 1'b0;
    #1;
    chk_out("rst_async", 1'b1, 1'b0, 32'h0);
`ifdef AHB_MUX_SEL_CHECK_EN
    chk("rst_sel_err", 32'(sel_err), 32'd0);
`endif
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    @(negedge hclk);
    chk_out("rst_release", 1'b1, 1'b0, 32'h0);
    @(posedge hclk);
    #1;

    // Random traffic against a transaction-level model: target of the last accepted address
    // phase, plus the number of ERROR cycles the default subordinate still owes.
    begin
      int          tgt;
      int          err_left;
      int          nt;
      logic [1:0]  tr;
      logic [2:0]  rdy;
      logic [2:0]  rsp;
      logic        e_rdy;
      logic        e_rsp;
      logic [31:0] e_data;
      logic [31:0] dat [3];
      tgt = -1;
      err_left = 0;
      for (int c = 0; c < 1500; c++) begin
        nt = $urandom_range(0, 4);
        tr = 2'($urandom_range(0, 3));
        if (nt == 4) tr[1] = 1'b0;
        rdy = 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7));
        rsp = 3'($urandom_range(0, 7));
        for (int k = 0; k < 3; k++) dat[k] = $urandom;
        hsel0 = (nt == 0); hsel1 = (nt == 1); hsel2 = (nt == 2); hseld = (nt == 3);
        htrans = tr;
        {hreadyout2, hreadyout1, hreadyout0} = rdy;
        {hresp2, hresp1, hresp0} = rsp;
        hrdata0 = dat[0]; hrdata1 = dat[1]; hrdata2 = dat[2];

        if (tgt < 0) begin
          e_rdy = 1'b1; e_rsp = 1'b0; e_data = 32'h0;
        end else if (tgt < 3) begin
          e_rdy = rdy[tgt]; e_rsp = rsp[tgt]; e_data = dat[tgt];
        end else begin
          e_rdy = (err_left != 2); e_rsp = (err_left != 0); e_data = 32'h0;
        end

        @(negedge hclk);
        chk_out($sformatf("rnd%0d", c), e_rdy, e_rsp, e_data);

        if (err_left == 2) err_left = 1;
        else if (e_rdy && nt == 3 && tr[1]) err_left = 2;
        else err_left = 0;
        if (e_rdy) tgt = (nt == 4) ? -1 : nt;

        @(posedge hclk);
        #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
